cook_sequencer: RTL

// - Front-panel sequencer for the microwave: accepts decoded keypad digits, loads the BCD timer, and sequences cook/pause/done.
// - Duty-cycles the magnetron per a user power level; gates it with the door interlock.
// - Sits between the keypad encoder, the BCD countdown timer and the magnetron drive.

---
 rtl/microwave_pkg.sv | 25 ++
 rtl/cook_sequencer_if.sv | 28 ++
 rtl/power_duty_gen.sv | 36 +++
 rtl/cook_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave front-panel sequencer.
package microwave_pkg;

  localparam int unsigned MAX_DIGITS    = 3;
  localparam int unsigned DUTY_SLOTS    = 10;
  localparam int unsigned DEFAULT_POWER = 10;
  localparam int unsigned DONE_HOLD     = 6;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned PWR_W   = 4;
  localparam int unsigned SLOT_W  = 4;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned HOLD_W  = 3;

  localparam logic [DIGIT_W-1:0] KEY_POWER = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_COOK,
    ST_PAUSE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cook_sequencer_if.sv
// Keypad/command inputs and timer/magnetron outputs of the cook sequencer.
interface cook_sequencer_if;
  logic       tick_1hz;
  logic       key_valid;
  logic [3:0] key_code;
  logic       start_p;
  logic       stop_p;
  logic       clear_p;
  logic       door_closed;
  logic       timer_zero;
  logic       timer_load;
  logic [3:0] timer_digit;
  logic       timer_clr;
  logic       timer_en;
  logic       mag_on;
  logic       done;
  logic       chime;

  modport master (
    output tick_1hz, key_valid, key_code, start_p, stop_p, clear_p, door_closed, timer_zero,
    input  timer_load, timer_digit, timer_clr, timer_en, mag_on, done, chime
  );

  modport slave (
    input  tick_1hz, key_valid, key_code, start_p, stop_p, clear_p, door_closed, timer_zero,
    output timer_load, timer_digit, timer_clr, timer_en, mag_on, done, chime
  );
endinterface

// File: rtl/power_duty_gen.sv
// Magnetron duty-cycle generator: 1 s slot counter compared against the power level.
module power_duty_gen
  import microwave_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             run,
  input  logic             hold,
  input  logic [PWR_W-1:0] power,
  output logic             mag_q
);

  logic [SLOT_W-1:0] slot_q, slot_d;

  // Slot advances while running, freezes while held, otherwise restarts at 0.
  always_comb begin
    slot_d = '0;
    if (run && tick) begin
      slot_d = (slot_q == SLOT_W'(DUTY_SLOTS - 1)) ? '0 : slot_q + SLOT_W'(1);
    end else if (run || hold) begin
      slot_d = slot_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q <= '0;
      mag_q  <= 1'b0;
    end else begin
      slot_q <= slot_d;
      mag_q  <= (slot_d < power);
    end
  end

endmodule

// File: rtl/cook_sequencer.sv
// Microwave front-panel sequencer: keypad entry, timer strobes, cook/pause/done control.
// Optional feature: define CHIME_EN to drive the audible chime during DONE.
module cook_sequencer
  import microwave_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  cook_sequencer_if.slave  bus
);

  state_t              state_q, state_d;
  logic [PWR_W-1:0]    power_q, power_d;
  logic [CNT_W-1:0]    digit_cnt_q, digit_cnt_d;
  logic                pwr_arm_q, pwr_arm_d;
  logic                pend_q, pend_d;
  logic [DIGIT_W-1:0]  pend_digit_q, pend_digit_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                timer_load_q, timer_load_d;
  logic [DIGIT_W-1:0]  timer_digit_q, timer_digit_d;
  logic                timer_clr_q, timer_clr_d;
  logic                timer_en_q, timer_en_d;
  logic                done_q, done_d;
  logic                mag_q;
  logic                key_digit, key_power;

  assign key_digit = bus.key_valid && (bus.key_code <= 4'd9);
  assign key_power = bus.key_valid && (bus.key_code == KEY_POWER);

  always_comb begin
    state_d       = state_q;
    power_d       = power_q;
    digit_cnt_d   = digit_cnt_q;
    pwr_arm_d     = pwr_arm_q;
    pend_d        = pend_q;
    pend_digit_d  = pend_digit_q;
    hold_cnt_d    = hold_cnt_q;
    timer_load_d  = 1'b0;
    timer_digit_d = '0;
    timer_clr_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // First digit clears the timer now and is shifted in on the next cycle.
        if (key_digit) begin
          timer_clr_d  = 1'b1;
          pend_d       = 1'b1;
          pend_digit_d = bus.key_code;
          digit_cnt_d  = CNT_W'(1);
          state_d      = ST_ENTRY;
        end else if (key_power) begin
          pwr_arm_d = 1'b1;
          state_d   = ST_ENTRY;
        end
      end

      ST_ENTRY: begin
        if (pend_q) begin
          timer_load_d  = 1'b1;
          timer_digit_d = pend_digit_q;
          pend_d        = 1'b0;
        end
        if (bus.clear_p) begin
          timer_load_d  = 1'b0;
          timer_digit_d = '0;
          timer_clr_d   = 1'b1;
          power_d       = PWR_W'(DEFAULT_POWER);
          state_d       = ST_IDLE;
        end else if (!bus.stop_p && bus.start_p && bus.door_closed && !bus.timer_zero) begin
          state_d = ST_COOK;
        end else if (key_digit && !pend_q) begin
          if (pwr_arm_q) begin
            power_d   = (bus.key_code == 4'd0) ? PWR_W'(DEFAULT_POWER) : PWR_W'(bus.key_code);
            pwr_arm_d = 1'b0;
          end else if (digit_cnt_q < CNT_W'(MAX_DIGITS)) begin
            timer_load_d  = 1'b1;
            timer_digit_d = bus.key_code;
            digit_cnt_d   = digit_cnt_q + CNT_W'(1);
          end
        end else if (key_power) begin
          pwr_arm_d = 1'b1;
        end
      end

      ST_COOK: begin
        if (bus.clear_p) begin
          timer_clr_d = 1'b1;
          power_d     = PWR_W'(DEFAULT_POWER);
          state_d     = ST_IDLE;
        end else if (bus.stop_p || !bus.door_closed) begin
          state_d = ST_PAUSE;
        end else if (bus.timer_zero) begin
          hold_cnt_d = '0;
          state_d    = ST_DONE;
        end
      end

      ST_PAUSE: begin
        if (bus.clear_p || bus.stop_p) begin
          timer_clr_d = 1'b1;
          power_d     = PWR_W'(DEFAULT_POWER);
          state_d     = ST_IDLE;
        end else if (bus.start_p && bus.door_closed) begin
          state_d = ST_COOK;
        end
      end

      ST_DONE: begin
        if (bus.key_valid || bus.clear_p || bus.stop_p) begin
          state_d = ST_IDLE;
        end else if (bus.tick_1hz) begin
          if (hold_cnt_q == HOLD_W'(DONE_HOLD - 1)) begin
            state_d = ST_IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Entry bookkeeping starts fresh every time the panel returns to idle.
    if (state_d == ST_IDLE) begin
      digit_cnt_d = '0;
      pwr_arm_d   = 1'b0;
      pend_d      = 1'b0;
    end

    timer_en_d = (state_d == ST_COOK);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      power_q       <= PWR_W'(DEFAULT_POWER);
      digit_cnt_q   <= '0;
      pwr_arm_q     <= 1'b0;
      pend_q        <= 1'b0;
      pend_digit_q  <= '0;
      hold_cnt_q    <= '0;
      timer_load_q  <= 1'b0;
      timer_digit_q <= '0;
      timer_clr_q   <= 1'b0;
      timer_en_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      power_q       <= power_d;
      digit_cnt_q   <= digit_cnt_d;
      pwr_arm_q     <= pwr_arm_d;
      pend_q        <= pend_d;
      pend_digit_q  <= pend_digit_d;
      hold_cnt_q    <= hold_cnt_d;
      timer_load_q  <= timer_load_d;
      timer_digit_q <= timer_digit_d;
      timer_clr_q   <= timer_clr_d;
      timer_en_q    <= timer_en_d;
      done_q        <= done_d;
    end
  end

  power_duty_gen u_duty (
    .clock (clock),
    .reset (reset),
    .tick  (bus.tick_1hz),
    .run   (state_q == ST_COOK),
    .hold  (state_q == ST_PAUSE),
    .power (power_q),
    .mag_q (mag_q)
  );

  assign bus.timer_load  = timer_load_q;
  assign bus.timer_digit = timer_digit_q;
  assign bus.timer_clr   = timer_clr_q;
  assign bus.timer_en    = timer_en_q;
  assign bus.done        = done_q;
  // Door opening must kill the magnetron without waiting for a clock edge.
  assign bus.mag_on      = mag_q && bus.door_closed && (state_q == ST_COOK);

`ifdef CHIME_EN
  logic chime_q;

  // Chime sounds on the odd-numbered tick periods of the DONE hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      chime_q <= 1'b0;
    end else begin
      chime_q <= (state_d == ST_DONE) && !hold_cnt_d[0];
    end
  end

  assign bus.chime = chime_q;
`else
  assign bus.chime = 1'b0;
`endif

endmodule
